// File: rtl/mac_pkg.sv
// Shared types and elaboration helpers for the MAC operand-buffer scheduler.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int unsigned depth_of(input int unsigned bw);
    return 32'd1 << bw;
  endfunction

  function automatic bit frame_len_ok(input int unsigned fl, input int unsigned bw);
    return (fl >= 1) && (fl <= depth_of(bw));
  endfunction

endpackage

// File: rtl/mac_buf_sched_if.sv
// Producer / buffer-address / MAC-control bundle of the operand scheduler.
interface mac_buf_sched_if #(parameter int unsigned BufferWidth = 2);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [BufferWidth-1:0] wr_ptr;
  logic [BufferWidth-1:0] rd_ptr;
  logic [BufferWidth:0]   count;
  logic                   full;
  logic                   empty;
  logic                   acc_clr;
  logic                   acc_en;
  logic                   acc_done;

  modport master (output wr_valid,
                  input  wr_ready, wr_ptr, rd_ptr, count, full, empty,
                         acc_clr, acc_en, acc_done);
  modport slave  (input  wr_valid,
                  output wr_ready, wr_ptr, rd_ptr, count, full, empty,
                         acc_clr, acc_en, acc_done);
endinterface

// File: rtl/mac_ring_ptr.sv
// Wrapping ring-buffer pointer; clear wins over enable.
module mac_ring_ptr #(parameter int unsigned W = 2) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)     ptr_d = '0;
    else if (en_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;

  assign ptr_o = ptr_q;
endmodule

// File: rtl/mac_buf_sched.sv
// Operand ring-buffer scheduler: tracks occupancy and sequences one MAC run
// (clear, FrameLen reads, done pulse) whenever a full frame is buffered.
module mac_buf_sched
  import mac_pkg::*;
#(
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned FrameLen    = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  mac_buf_sched_if.slave  bus
);
  localparam int unsigned Depth = depth_of(BufferWidth);
  localparam logic [BufferWidth:0]   DepthC   = (BufferWidth+1)'(Depth);
  localparam logic [BufferWidth:0]   FrameC   = (BufferWidth+1)'(FrameLen);
  localparam logic [BufferWidth-1:0] LastBeat = BufferWidth'(FrameLen - 1);

  if (!frame_len_ok(FrameLen, BufferWidth)) begin : g_bad_frame_len
    $error("mac_buf_sched: FrameLen must be within 1..Depth");
  end

  logic [BufferWidth:0]   count_q, count_d;
  logic [BufferWidth-1:0] beat_q;
  state_e                 state_q;
  logic                   acc_en_q, acc_clr_q, acc_done_q;
  logic                   full, wr_fire, rd_fire;

  assign full    = (count_q == DepthC);
  assign wr_fire = bus.wr_valid & ~full & ~flush_i;
  assign rd_fire = acc_en_q & ~flush_i;

  mac_ring_ptr #(.W(BufferWidth)) u_wr_ptr (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(wr_fire), .clr_i(flush_i), .ptr_o(bus.wr_ptr));
  mac_ring_ptr #(.W(BufferWidth)) u_rd_ptr (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(rd_fire), .clr_i(flush_i), .ptr_o(bus.rd_ptr));

  always_comb begin
    count_d = count_q;
    if (flush_i)                 count_d = '0;
    else if (wr_fire && !rd_fire) count_d = count_q + 1'b1;
    else if (rd_fire && !wr_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;

  // The frame is reserved on entry to RUN, so reads never outrun the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE; beat_q <= '0;
      acc_en_q <= 1'b0; acc_clr_q <= 1'b0; acc_done_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE; beat_q <= '0;
      acc_en_q <= 1'b0; acc_clr_q <= 1'b0; acc_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (count_q >= FrameC) begin
          state_q <= RUN; beat_q <= '0; acc_en_q <= 1'b1; acc_clr_q <= 1'b1;
        end
        RUN: begin
          acc_clr_q <= 1'b0;
          if (beat_q == LastBeat) begin
            state_q <= DONE; beat_q <= '0; acc_en_q <= 1'b0; acc_done_q <= 1'b1;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        DONE: begin
          acc_done_q <= 1'b0;
          if (count_q >= FrameC) begin
            state_q <= RUN; acc_en_q <= 1'b1; acc_clr_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.empty    = (count_q == '0);
  assign bus.wr_ready = ~full;
  assign bus.acc_en   = acc_en_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.acc_done = acc_done_q;
endmodule

// File: tb/tb_mac_buf_sched.sv
// Self-checking bench for mac_buf_sched: vector table, address scoreboard, corner sequences.
module tb_mac_buf_sched;
  logic clk = 1'b0, rst_n = 1'b0, flush_a = 1'b0, flush_b = 1'b0;
  always #5 clk = ~clk;

  mac_buf_sched_if #(.BufferWidth(2)) ifa();
  mac_buf_sched_if #(.BufferWidth(2)) ifb();

  mac_buf_sched #(.BufferWidth(2), .FrameLen(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a), .bus(ifa.slave));
  mac_buf_sched #(.BufferWidth(2), .FrameLen(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b), .bus(ifb.slave));

  typedef struct {
    logic       wv;
    logic [1:0] wp, rp;
    logic [2:0] cnt;
    logic       full, empty, clr, en, done;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  logic [1:0] sb_q[$];
  logic [1:0] mw;
  int mbeat;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sb_reset();
    sb_q.delete(); mw = '0; mbeat = 0;
  endtask

  // Scoreboard for dut_a on the cycle ending at the next edge, then advance.
  task automatic step();
    logic [1:0] a;
    logic fl;
    fl = flush_a;
    if (!fl && rst_n) begin
      if (ifa.acc_en) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_read_without_write: rd_ptr %0d with empty scoreboard", ifa.rd_ptr);
        end else begin
          a = sb_q.pop_front();
          chk("sb_rd_ptr", 16'(ifa.rd_ptr), 16'(a));
          chk("sb_acc_clr", 16'(ifa.acc_clr), 16'(mbeat == 0));
          mbeat = (mbeat + 1) % 4;
        end
      end
      if (ifa.wr_valid && ifa.wr_ready) begin sb_q.push_back(mw); mw = mw + 1'b1; end
    end
    @(posedge clk); #1;
    if (fl) sb_reset();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".wp"},   16'(ifa.wr_ptr), 0);
    chk({tag, ".rp"},   16'(ifa.rd_ptr), 0);
    chk({tag, ".cnt"},  16'(ifa.count), 0);
    chk({tag, ".empty"},16'(ifa.empty), 1);
    chk({tag, ".full"}, 16'(ifa.full), 0);
    chk({tag, ".rdy"},  16'(ifa.wr_ready), 1);
    chk({tag, ".acc"},  16'({ifa.acc_clr, ifa.acc_en, ifa.acc_done}), 0);
  endtask

  vec_t tbl[10];

  initial begin
    int n_done, seen_b2b;
    bit rp_wrap, wp_wrap, prev_done, hit;
    logic [2:0] c;
    logic [1:0] prp, pwp;
    bit ov;
    int n_en;

    ifa.wr_valid = 1'b0; ifb.wr_valid = 1'b0;
    sb_reset();

    tbl[0] = '{1'b1, 2'd1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'd2, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd3, 2'd0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 2'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 2'd0, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // 1: reset values
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk_reset_a("t1");
    chk("t1.b_cnt", 16'(ifb.count), 0);

    // 2: fill one frame and run it
    for (int i = 0; i < 10; i++) begin
      ifa.wr_valid = tbl[i].wv;
      step();
      chk($sformatf("t2[%0d].wp", i),   16'(ifa.wr_ptr),   16'(tbl[i].wp));
      chk($sformatf("t2[%0d].rp", i),   16'(ifa.rd_ptr),   16'(tbl[i].rp));
      chk($sformatf("t2[%0d].cnt", i),  16'(ifa.count),    16'(tbl[i].cnt));
      chk($sformatf("t2[%0d].full", i), 16'(ifa.full),     16'(tbl[i].full));
      chk($sformatf("t2[%0d].empty", i),16'(ifa.empty),    16'(tbl[i].empty));
      chk($sformatf("t2[%0d].rdy", i),  16'(ifa.wr_ready), 16'(!tbl[i].full));
      chk($sformatf("t2[%0d].clr", i),  16'(ifa.acc_clr),  16'(tbl[i].clr));
      chk($sformatf("t2[%0d].en", i),   16'(ifa.acc_en),   16'(tbl[i].en));
      chk($sformatf("t2[%0d].done", i), 16'(ifa.acc_done), 16'(tbl[i].done));
    end

    // 3: continuous writes across several runs
    n_done = 0; rp_wrap = 0; wp_wrap = 0;
    ifa.wr_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ov = ifa.acc_en && ifa.wr_valid && ifa.wr_ready;
      c = ifa.count; prp = ifa.rd_ptr; pwp = ifa.wr_ptr;
      step();
      if (ov) chk("t3.overlap_cnt", 16'(ifa.count), 16'(c));
      if (prp == 2'd3 && ifa.rd_ptr == 2'd0) rp_wrap = 1;
      if (pwp == 2'd3 && ifa.wr_ptr == 2'd0) wp_wrap = 1;
      if (ifa.acc_done) n_done++;
      if (ifa.count > 3'd4) chk("t3.cnt_le_depth", 16'(ifa.count), 4);
    end
    chk("t3.runs_ge_3", 16'(n_done >= 3), 1);
    chk("t3.rp_wrap", 16'(rp_wrap), 1);
    chk("t3.wp_wrap", 16'(wp_wrap), 1);
    ifa.wr_valid = 1'b0;
    flush_a = 1'b1; step(); flush_a = 1'b0;
    chk_reset_a("t3.flush");

    // 5: flush on the second beat of a run
    ifa.wr_valid = 1'b1;
    repeat (4) step();
    ifa.wr_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      step();
      hit = ifa.acc_en && !ifa.acc_clr;
    end
    chk("t5.second_beat_seen", 16'(hit), 1);
    flush_a = 1'b1; step(); flush_a = 1'b0;
    chk_reset_a("t5");
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifa.acc_done || ifa.acc_en) hit = 1;
    end
    chk("t5.no_done_after_flush", 16'(hit), 0);

    // 6: asynchronous reset in the middle of a run
    ifa.wr_valid = 1'b1;
    repeat (4) step();
    ifa.wr_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 4 && !hit; i++) begin step(); hit = ifa.acc_en; end
    chk("t6.run_started", 16'(hit), 1);
    #1 rst_n = 1'b0; #1;
    chk_reset_a("t6");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; sb_reset(); #1;
    chk("t6.b_cnt", 16'(ifb.count), 0);

    // 4: FrameLen=2 with 3 writes -> one run, one leftover
    n_en = 0; n_done = 0;
    ifb.wr_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) ifb.wr_valid = 1'b0;
      step();
      if (ifb.acc_en) n_en++;
      if (ifb.acc_done) n_done++;
    end
    chk("t4.en_beats", 16'(n_en), 2);
    chk("t4.done_pulses", 16'(n_done), 1);
    chk("t4.cnt", 16'(ifb.count), 1);
    chk("t4.rp", 16'(ifb.rd_ptr), 2);
    chk("t4.wp", 16'(ifb.wr_ptr), 3);
    ifb.wr_valid = 1'b1; step(); ifb.wr_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 6 && !ifb.acc_done; i++) begin
      step();
      if (ifb.acc_en) hit = 1;
    end
    chk("t4.run_after_4th", 16'(hit), 1);
    chk("t4.done_after_4th", 16'(ifb.acc_done), 1);
    step();

    // 3b: back-to-back frames with FrameLen=2
    seen_b2b = 0; prev_done = 0;
    ifb.wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (prev_done) begin
        chk("t3b.b2b_restart", 16'(ifb.acc_en && ifb.acc_clr), 1);
        seen_b2b++;
      end
      prev_done = ifb.acc_done;
    end
    ifb.wr_valid = 1'b0;
    chk("t3b.b2b_seen", 16'(seen_b2b >= 2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
